// File: rtl/spi_master.sv
// spi_master: byte-wide SPI mode-0 shift engine with a one-byte holding register
module spi_master #(
    parameter int CLKDIV = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce,
    input  logic       spi_wren,
    input  logic [7:0] spi_do,
    output logic       spi_dsr,
    output logic [7:0] spi_di,
    output logic       busy,
    output logic       done,
    output logic       overrun,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso
);
    typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, DONE} state_t;
    localparam logic [7:0] DIV_LAST = 8'(CLKDIV - 1);
    state_t     state, state_d;
    logic [7:0] div_cnt, div_d, tx, tx_d, rx, rx_d, hold, hold_d, di_d;
    logic [2:0] bit_cnt, bit_d;
    logic       hold_full, hold_full_d, done_d, ovr_d, sclk_d, mosi_d, wr, last;
    assign wr   = ce & spi_wren;
    assign last = div_cnt == DIV_LAST;
    assign busy = state != IDLE;
    // Next-state logic: phase timing, shifting, byte completion and write acceptance
    always_comb begin
        state_d     = state;
        div_d       = div_cnt;
        bit_d       = bit_cnt;
        tx_d        = tx;
        rx_d        = rx;
        hold_d      = hold;
        hold_full_d = hold_full;
        di_d        = spi_di;
        done_d      = 1'b0;
        ovr_d       = 1'b0;
        sclk_d      = sclk;
        mosi_d      = mosi;
        case (state)
            IDLE: if (wr) begin
                state_d = SHIFT_LO;
                tx_d    = spi_do;
                mosi_d  = spi_do[7];
                sclk_d  = 1'b0;
                div_d   = '0;
                bit_d   = '0;
            end
            SHIFT_LO: begin
                div_d = last ? 8'd0 : div_cnt + 8'd1;
                if (last) begin
                    state_d = SHIFT_HI;
                    sclk_d  = 1'b1;
                    rx_d    = {rx[6:0], miso};
                end
            end
            SHIFT_HI: begin
                div_d = last ? 8'd0 : div_cnt + 8'd1;
                if (last) begin
                    sclk_d = 1'b0;
                    if (bit_cnt != 3'd7) begin
                        state_d = SHIFT_LO;
                        bit_d   = bit_cnt + 3'd1;
                        tx_d    = {tx[6:0], 1'b0};
                        mosi_d  = tx[6];
                    end else begin
                        state_d = DONE;
                        di_d    = rx;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                div_d = '0;
                bit_d = '0;
                if (hold_full) begin
                    state_d     = SHIFT_LO;
                    tx_d        = hold;
                    mosi_d      = hold[7];
                    hold_full_d = 1'b0;
                end else if (wr) begin
                    state_d = SHIFT_LO;
                    tx_d    = spi_do;
                    mosi_d  = spi_do[7];
                end else begin
                    state_d = IDLE;
                    mosi_d  = 1'b1;
                end
            end
        endcase
        // While shifting, a write lands in hold; in DONE the hold slot is being freed, so it refills
        if (wr && state != IDLE && !(state == DONE && !hold_full)) begin
            if (!hold_full || state == DONE) begin
                hold_d      = spi_do;
                hold_full_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end
    // State and output registers; reset abandons any transfer and the held byte
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            tx        <= '0;
            rx        <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            spi_dsr   <= 1'b1;
            spi_di    <= 8'hFF;
            done      <= 1'b0;
            overrun   <= 1'b0;
            sclk      <= 1'b0;
            mosi      <= 1'b1;
        end else begin
            state     <= state_d;
            div_cnt   <= div_d;
            bit_cnt   <= bit_d;
            tx        <= tx_d;
            rx        <= rx_d;
            hold      <= hold_d;
            hold_full <= hold_full_d;
            spi_dsr   <= ~hold_full_d;
            spi_di    <= di_d;
            done      <= done_d;
            overrun   <= ovr_d;
            sclk      <= sclk_d;
            mosi      <= mosi_d;
        end
    end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: scoreboard bench for spi_master with directed vectors
module tb_spi_master;
    logic       clk, reset_n, ce, spi_wren, miso, loop_en;
    logic [7:0] spi_do, spi_di;
    logic       spi_dsr, busy, done, overrun, sclk, mosi;
    int         n_chk = 0, n_fail = 0, ov_cnt = 0;
    typedef struct packed { logic [7:0] tx; logic [7:0] rx; } exp_t;
    exp_t       exp_q[$];

    spi_master #(.CLKDIV(4)) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce), .spi_wren(spi_wren), .spi_do(spi_do),
        .spi_dsr(spi_dsr), .spi_di(spi_di), .busy(busy), .done(done), .overrun(overrun),
        .sclk(sclk), .mosi(mosi), .miso(miso)
    );

    assign miso = loop_en ? mosi : 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] t, input logic [7:0] r);
        exp_q.push_back({t, r});
    endtask

    task automatic write(input logic [7:0] b);
        @(negedge clk);
        spi_wren = 1'b1;
        spi_do   = b;
        @(negedge clk);
        spi_wren = 1'b0;
    endtask

    // returns at the negedge where done is high; nb counts idle cycles seen on the way
    task automatic wait_done(output int n, output int nb);
        n  = 0;
        nb = 0;
        do begin
            @(negedge clk);
            n++;
            if (!busy) nb++;
        end while (!done && n < 2000);
        if (!done) chk("done_timeout", 32'(n), 32'd0);
    endtask

    // Monitor: scores every completed byte and watches mode-0 mosi timing
    logic [7:0] bits;
    int         rises;
    logic       ps, pm;
    always @(negedge clk) begin
        if (!reset_n) begin
            rises = 0;
            bits  = '0;
        end else begin
            if (mosi !== pm) chk("mosi_change_sclk_low", 32'(sclk), 32'd0);
            if (sclk && !ps) begin
                rises++;
                bits = {bits[6:0], mosi};
            end
            if (overrun) ov_cnt++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_done: spi_di %0h with empty scoreboard", spi_di);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("spi_di", 32'(spi_di), 32'(e.rx));
                    chk("mosi_bits", 32'(bits), 32'(e.tx));
                    chk("sclk_rises", 32'(rises), 32'd8);
                end
                rises = 0;
            end
        end
        ps = sclk;
        pm = mosi;
    end

    initial begin
        int n, nb, m, ov0, act, r;
        logic p;
        reset_n = 1'b0; ce = 1'b1; spi_wren = 1'b0; spi_do = '0; loop_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_dsr", 32'(spi_dsr), 32'd1);
        chk("rst_di", 32'(spi_di), 32'hFF);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done_ovr", 32'({done, overrun}), 32'd0);
        chk("rst_sclk_mosi", 32'({sclk, mosi}), 32'b01);
        reset_n = 1'b1;
        // single write
        push(8'hA5, 8'hA5);
        write(8'hA5);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_mosi_bit7", 32'(mosi), 32'd1);
        wait_done(n, nb);
        chk("t1_done_lat", 32'(n), 32'd64);
        @(negedge clk);
        chk("t1_idle", 32'({busy, sclk, mosi}), 32'b001);
        // queued write
        push(8'h3C, 8'h3C);
        push(8'hC3, 8'hC3);
        write(8'h3C);
        repeat (8) @(negedge clk);
        write(8'hC3);
        chk("t2_dsr_low", 32'(spi_dsr), 32'd0);
        wait_done(n, nb);
        chk("t2_dsr_done", 32'(spi_dsr), 32'd0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) chk("t2_dsr_free", 32'(spi_dsr), 32'd1);
        end while (!sclk && n < 100);
        chk("t2_first_rise", 32'(n), 32'd5);
        wait_done(m, nb);
        chk("t2_done_gap", 32'(n + m), 32'd65);
        chk("t2_no_idle", 32'(nb), 32'd0);
        // overrun
        push(8'h01, 8'h01);
        push(8'h02, 8'h02);
        ov0 = ov_cnt;
        @(negedge clk); spi_wren = 1'b1; spi_do = 8'h01;
        @(negedge clk); spi_do = 8'h02;
        @(negedge clk); spi_do = 8'h03;
        @(negedge clk); spi_wren = 1'b0;
        chk("t3_overrun", 32'(overrun), 32'd1);
        @(negedge clk);
        chk("t3_overrun_pulse", 32'(overrun), 32'd0);
        wait_done(n, nb);
        wait_done(n, nb);
        chk("t3_overrun_count", 32'(ov_cnt - ov0), 32'd1);
        repeat (80) @(negedge clk);
        chk("t3_idle", 32'(busy), 32'd0);
        // write in the DONE cycle with empty hold
        push(8'hAA, 8'hAA);
        push(8'h55, 8'h55);
        ov0 = ov_cnt;
        write(8'hAA);
        wait_done(n, nb);
        spi_wren = 1'b1;
        spi_do   = 8'h55;
        @(negedge clk);
        spi_wren = 1'b0;
        chk("t4_busy", 32'(busy), 32'd1);
        chk("t4_mosi_bit7", 32'(mosi), 32'd0);
        wait_done(n, nb);
        chk("t4_done_lat", 32'(n), 32'd64);
        chk("t4_no_idle", 32'(nb), 32'd0);
        chk("t4_no_overrun", 32'(ov_cnt - ov0), 32'd0);
        @(negedge clk);
        // reset mid-transfer with a held byte
        write(8'h96);
        write(8'h69);
        r = 0; n = 0; p = sclk;
        do begin
            @(negedge clk);
            n++;
            if (sclk && !p) r++;
            p = sclk;
        end while (r < 3 && n < 1000);
        chk("t5_three_rises", 32'(r), 32'd3);
        reset_n = 1'b0;
        #1;
        chk("t5_rst_sclk_mosi", 32'({sclk, mosi}), 32'b01);
        chk("t5_rst_dsr", 32'(spi_dsr), 32'd1);
        chk("t5_rst_di", 32'(spi_di), 32'hFF);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        act = 0;
        repeat (200) begin
            @(negedge clk);
            if (done || sclk || busy || !mosi) act++;
        end
        chk("t5_quiet", 32'(act), 32'd0);
        // ce gating
        loop_en = 1'b0;
        push(8'h5A, 8'hFF);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            spi_wren = 1'b1;
            spi_do   = 8'h5A;
            ce       = (i == 3);
        end
        @(negedge clk);
        spi_wren = 1'b0;
        ce       = 1'b0;
        chk("t6_busy", 32'(busy), 32'd1);
        wait_done(n, nb);
        chk("t6_done_lat", 32'(n), 32'd64);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            ce = (i % 4 == 3);
        end
        chk("t6_idle", 32'(busy), 32'd0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Byte-wide SPI shift engine behind the core's user register (177714).
- Consumes the core's write strobe and byte (spi_wren/spi_do).
- Returns the ready flag and the last received byte (spi_dsr/spi_di) that the core exposes to software.
- Drives SCLK/MOSI to the SD card in SPI mode 0. Chip select stays with the core; this block does not touch it.
- A one-byte holding register lets software queue the next byte while the current one shifts.

Parameters:
- CLKDIV, 4: SCLK half-period in clk cycles; must be 1..255. Independent of ce.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- ce  in  1  core clock enable; qualifies spi_wren only
- spi_wren  in  1  write strobe from core; sampled as wr = ce & spi_wren
- spi_do  in  8  byte to transmit, valid when wr
- spi_dsr  out  1  1 = holding register empty, a write will be accepted
- spi_di  out  8  last fully received byte
- busy  out  1  1 = shifter active
- done  out  1  one-clk pulse when a byte completes
- overrun  out  1  one-clk pulse when a write is dropped
- sclk  out  1  SPI clock, idle low
- mosi  out  1  SPI data out, MSB first, idle high
- miso  in  1  SPI data in

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - reset_n is asynchronous and active-low. It overrides everything, including a transfer in progress.
  - After reset the transfer is abandoned, no done pulse is emitted, and the held byte is discarded.
- Reset values:
  - spi_dsr=1, spi_di=8'hFF, busy=0, done=0, overrun=0, sclk=0, mosi=1.
  - Internal: state=IDLE, hold_full=0, div_cnt=0, bit_cnt=0.
- Write acceptance, when wr is sampled at cycle T:
  - State IDLE: the byte loads the shifter. Cycle T+1: state=SHIFT_LO, busy=1, mosi=bit7, sclk=0. hold_full is unchanged.
  - State not IDLE and hold_full=0: the byte goes to the holding register; hold_full=1 from T+1.
  - State not IDLE and hold_full=1: the byte is dropped and overrun=1 at T+1 for one cycle. Held and shifting data are unchanged.
- spi_dsr = ~hold_full, registered.
- State machine, with div_cnt counting 0..CLKDIV-1 in each phase:
  - IDLE: sclk=0, mosi=1, busy=0.
  - SHIFT_LO: sclk=0 for CLKDIV cycles, then go to SHIFT_HI.
    - On entering SHIFT_HI: sclk=1 and rx <= {rx[6:0], miso}, sampled on the rising edge.
  - SHIFT_HI: sclk=1 for CLKDIV cycles, then:
    - If bit_cnt<7: bit_cnt++, sclk=0, shift tx left, mosi=next bit, go to SHIFT_LO.
    - If bit_cnt==7: go to DONE.
  - DONE, one cycle: sclk=0, spi_di<=rx, done=1.
    - If hold_full: load the shifter from hold, hold_full=0, next state SHIFT_LO, mosi=new bit7.
    - Otherwise: next state IDLE, mosi=1.
- Timing and latency:
  - Accepted at T: first rising SCLK at T+1+CLKDIV; spi_di valid and done at T+1+16*CLKDIV.
  - Back-to-back bytes: the queued byte starts in the cycle after DONE, with no extra idle SCLK phase. Byte period is 16*CLKDIV+1 clks.
- Simultaneous wr in the DONE cycle:
  - hold_full=1: the shifter takes hold and the new byte goes into hold (not overrun).
  - hold_full=0, next state IDLE: the new byte goes directly to the shifter, as an IDLE-equivalent accept. State goes to SHIFT_LO, busy stays 1.
- Edge cases:
  - spi_wren high with ce low is ignored.
  - With ce held at 1, a strobe that is high for one clk is one write.
- Ordering:
  - spi_di changes only in the DONE cycle.
  - done and spi_di update in the same cycle.
  - The data-ready indication software sees at the core's user-register bit 8 follows spi_dsr directly.
- Mode 0 compliance:
  - mosi changes only while sclk=0, at least CLKDIV cycles before each rising edge.
  - miso is sampled exactly at each rising edge.

Test Plan:
1. Reset, then single write.
   - Stimulus: CLKDIV=4, ce=1, write 8'hA5 with miso looped to mosi.
   - Required: busy at T+1; exactly 8 rising sclk edges; mosi sequence 1,0,1,0,0,1,0,1; done pulse at T+65; spi_di=8'hA5; then idle, sclk=0, mosi=1.
2. Queued write.
   - Stimulus: write 8'h3C, then write 8'hC3 10 cycles later.
   - Required: spi_dsr=0 from the second write until the DONE cycle of the first byte; second byte's first rising edge 1+CLKDIV cycles after the first done; two done pulses 65 clks apart.
3. Overrun.
   - Stimulus: three writes (8'h01, 8'h02, 8'h03) in three consecutive ce cycles.
   - Required: overrun pulses once on the third; transmitted bytes are 01 then 02 only.
4. Write in the DONE cycle with an empty hold.
   - Stimulus: write 8'h55 coinciding with done.
   - Required: busy never drops; next byte starts immediately; no overrun.
5. Reset mid-transfer.
   - Stimulus: assert reset_n low after 3 sclk rises, with a held byte pending.
   - Required: sclk=0, mosi=1, spi_dsr=1, spi_di=8'hFF immediately; no done; no further activity after release.
6. ce gating.
   - Stimulus: ce=1 every 4th clk; spi_wren held 4 clks.
   - Required: exactly one byte accepted; miso tied to 1 gives spi_di=8'hFF.
